multicycle_controller: RTL and testbench

Moore-style control FSM that sequences the shared multicycle RISC-V datapath: one ALU, one memory port, the register file and the immediate extend unit, reused across several cycles per instruction. It decodes the instruction register fields and drives every datapath select and write enable, including `immSrc` for the extend unit. It sits beside the datapath at the top of the multicycle processor.

---
 rtl/riscv_ctrl_pkg.sv | 54 +++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 116 +++++++++++
 tb/tb_multicycle_controller.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control path.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ERROR
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Extend unit select, also consumed by the datapath's extend unit.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Immediate format depends only on the opcode, never on the state.
  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction fields onto the ALU operation select.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control,
  output logic       o_bad_funct
);

  // Unsupported funct3 falls back to add and raises the bad flag.
  always_comb begin
    o_alu_control = ALU_ADD;
    o_bad_funct   = 1'b0;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_bad_funct   = 1'b1;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the shared multicycle RISC-V datapath.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcWrite,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic [1:0] resultSrc,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] immSrc,
  output logic       regWrite,
  output logic [2:0] aluControl,
  output logic       illegal
);

  state_t     r_state, w_next;
  logic       r_illegal;
  logic       w_pc_update, w_branch, w_mem_write, w_ir_write, w_reg_write;
  logic [1:0] w_alu_op;
  logic       w_bad_funct;

  // State register; reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECR;
          OP_ITYPE:     w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_next = S_ERROR;
        endcase
      end
      S_MEMADR:  w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: w_next = S_MEMWB;
      S_EXECR, S_EXECI, S_JAL: w_next = S_ALUWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: w_next = S_FETCH;
      S_ERROR:   w_next = S_ERROR;
      default:   w_next = S_FETCH;
    endcase
  end

  // Moore outputs per state; everything defaults to 0.
  always_comb begin
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    adrSrc      = 1'b0;
    resultSrc   = RES_ALUOUT;
    aluSrcA     = SRCA_PC;
    aluSrcB     = SRCB_B;
    w_alu_op    = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_ir_write = 1'b1; w_pc_update = 1'b1;
        aluSrcB = SRCB_FOUR; resultSrc = RES_ALURESULT;
      end
      S_DECODE:   begin aluSrcA = SRCA_OLDPC; aluSrcB = SRCB_IMM; end
      S_MEMADR:   begin aluSrcA = SRCA_A;     aluSrcB = SRCB_IMM; end
      S_MEMREAD:  adrSrc = 1'b1;
      S_MEMWB:    begin resultSrc = RES_DATA; w_reg_write = 1'b1; end
      S_MEMWRITE: begin adrSrc = 1'b1; w_mem_write = 1'b1; end
      S_EXECR:    begin aluSrcA = SRCA_A; aluSrcB = SRCB_B;   w_alu_op = ALUOP_FUNCT; end
      S_EXECI:    begin aluSrcA = SRCA_A; aluSrcB = SRCB_IMM; w_alu_op = ALUOP_FUNCT; end
      S_ALUWB:    w_reg_write = 1'b1;
      S_BEQ:      begin aluSrcA = SRCA_A; w_alu_op = ALUOP_SUB; w_branch = 1'b1; end
      S_JAL: begin
        aluSrcA = SRCA_OLDPC; aluSrcB = SRCB_FOUR; w_pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_dec (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3),
    .i_op5         (op[5]),
    .i_funct7b5    (funct7b5),
    .o_alu_control (aluControl),
    .o_bad_funct   (w_bad_funct)
  );

  // Sticky illegal flag: bad opcode on entry to ERROR, or bad funct3 in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_illegal <= 1'b0;
    else if (w_next == S_ERROR || w_bad_funct) r_illegal <= 1'b1;
  end

  // Write enables are masked by reset so an abort drops them immediately.
  assign pcWrite  = rst_n & (w_pc_update | (w_branch & zero));
  assign irWrite  = rst_n & w_ir_write;
  assign regWrite = rst_n & w_reg_write;
  assign memWrite = rst_n & w_mem_write;
  assign immSrc   = imm_sel(op);
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized and directed checks of the multicycle controller against a phase model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
  logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
  logic [2:0] aluControl;

  int checks = 0;
  int errors = 0;
  logic ill_m = 1'b0;

  typedef enum {P_RST, P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL, P_ERROR} phase_e;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite),
    .irWrite(irWrite), .resultSrc(resultSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .immSrc(immSrc), .regWrite(regWrite), .aluControl(aluControl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB,
                immSrc, regWrite, aluControl, illegal};

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    if (o == 7'b0000011 || o == 7'b0010011) return 2'd0;
    if (o == 7'b0100011) return 2'd1;
    if (o == 7'b1100011) return 2'd2;
    if (o == 7'b1101111) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic f3_ok(input logic [2:0] f);
    return (f == 3'd0 || f == 3'd2 || f == 3'd6 || f == 3'd7);
  endfunction

  function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f, input logic f7);
    if (f == 3'd0) return (o[5] && f7) ? 3'd1 : 3'd0;
    if (f == 3'd2) return 3'd5;
    if (f == 3'd6) return 3'd3;
    if (f == 3'd7) return 3'd2;
    return 3'd0;
  endfunction

  // Expected output vector for one cycle, straight from the per-phase output list.
  function automatic logic [16:0] phase_vec(input phase_e ph, input logic [6:0] o,
      input logic [2:0] f, input logic f7, input logic z, input logic ill);
    logic pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] ac;
    {pcw, adr, mw, irw, rw} = '0;
    rs = 2'd0; sa = 2'd0; sb = 2'd0; ac = 3'd0;
    case (ph)
      P_RST:      begin sb = 2'd2; rs = 2'd2; end
      P_FETCH:    begin irw = 1; pcw = 1; sb = 2'd2; rs = 2'd2; end
      P_DECODE:   begin sa = 2'd1; sb = 2'd1; end
      P_MEMADR:   begin sa = 2'd2; sb = 2'd1; end
      P_MEMREAD:  adr = 1;
      P_MEMWB:    begin rs = 2'd1; rw = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; end
      P_EXECR:    begin sa = 2'd2; ac = exp_alu(o, f, f7); end
      P_EXECI:    begin sa = 2'd2; sb = 2'd1; ac = exp_alu(o, f, f7); end
      P_ALUWB:    rw = 1;
      P_BEQ:      begin sa = 2'd2; ac = 3'd1; pcw = z; end
      P_JAL:      begin sa = 2'd1; sb = 2'd2; pcw = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, sa, sb, exp_imm(o), rw, ac, ill};
  endfunction

  task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // Runs one instruction from FETCH; stop_at >= 0 leaves it parked mid-instruction.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic f7,
                           input logic z, input int stop_at, input int err_cycles);
    phase_e q[$];
    q = '{P_FETCH, P_DECODE};
    case (o)
      7'b0000011: q = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB};
      7'b0100011: q = '{P_FETCH, P_DECODE, P_MEMADR, P_MEMWRITE};
      7'b0110011: q = '{P_FETCH, P_DECODE, P_EXECR, P_ALUWB};
      7'b0010011: q = '{P_FETCH, P_DECODE, P_EXECI, P_ALUWB};
      7'b1100011: q = '{P_FETCH, P_DECODE, P_BEQ};
      7'b1101111: q = '{P_FETCH, P_DECODE, P_JAL, P_ALUWB};
      default: for (int k = 0; k < err_cycles; k++) q.push_back(P_ERROR);
    endcase
    op = o; funct3 = f; funct7b5 = f7; zero = z;
    foreach (q[i]) begin
      #1;
      chk(q[i].name(), obs, phase_vec(q[i], o, f, f7, z, ill_m));
      if (q[i] == P_BEQ) begin
        zero = ~z; #1;
        checks++;
        assert (pcWrite === ~z) else begin
          errors++;
          $error("FAIL BEQ_zero_toggle observed=%b expected=%b", pcWrite, ~z);
        end
        zero = z;
      end
      if (i == stop_at) return;
      if ((q[i] == P_EXECR || q[i] == P_EXECI) && !f3_ok(f)) ill_m = 1'b1;
      if (q[i] == P_DECODE && q.size() > 2 && q[2] == P_ERROR) ill_m = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ill_m = 1'b0;
    #1;
    chk("RESET", obs, phase_vec(P_RST, op, funct3, funct7b5, zero, 1'b0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [6:0] ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};

  initial begin
    op = 7'b0000011; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    do_reset();

    // Directed coverage of each instruction class.
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, -1, 0);  // lw
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, -1, 0);  // sw
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, -1, 0);  // sub
    run_instr(7'b0110011, 3'd7, 1'b0, 1'b0, -1, 0);  // and
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, -1, 0);  // addi, funct7b5 ignored
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, -1, 0);  // beq taken
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, -1, 0);  // beq not taken
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, -1, 0);  // jal
    run_instr(7'b0010011, 3'd1, 1'b0, 1'b0, -1, 0);  // bad funct3 -> illegal
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, -1, 0);  // illegal stays set
    do_reset();

    // Randomized instruction stream.
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 0);

    // Abort mid-MEMWRITE: write enable must drop while reset is low.
    do_reset();
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 3, 0);
    do_reset();
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, -1, 0);

    // Unsupported opcode: ERROR is absorbing with illegal set.
    run_instr(7'b1111111, 3'd0, 1'b0, 1'b1, -1, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
